// File: rtl/trace_tx_pkg.sv
// Shared types and constants for the pipeline trace transmitter.
package trace_tx_pkg;

    localparam int unsigned TRACE_XLEN      = 32;
    localparam int unsigned TRACE_BYTE_W    = 8;
    localparam logic [7:0]  TRACE_HDR       = 8'hA5;
    localparam int unsigned TRACE_REC_BYTES = 14;
    localparam int unsigned FRAME_W         = TRACE_REC_BYTES * TRACE_BYTE_W;

    // Hazard flag byte; field order fixes the bit indices (stall=0, rs1=1, rs2=2).
    typedef struct packed {
        logic [4:0] rsvd;
        logic       rs2_hzd;
        logic       rs1_hzd;
        logic       stall;
    } trace_flags_t;

    // One buffered record: 104 bits of flags+pc+inst+alu.
    typedef struct packed {
        trace_flags_t            flags;
        logic [TRACE_XLEN-1:0]   pc;
        logic [TRACE_XLEN-1:0]   inst;
        logic [TRACE_XLEN-1:0]   alu;
    } trace_rec_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_t;

    // Frame image with byte 0 in the low bits, each field little-endian.
    function automatic logic [FRAME_W-1:0] build_frame(input trace_rec_t r);
        return {r.alu, r.inst, r.pc, r.flags, TRACE_HDR};
    endfunction

endpackage

// File: rtl/trace_tx_if.sv
// Record capture inputs plus the byte-wide valid/ready trace stream.
interface trace_tx_if
    import trace_tx_pkg::*;
;
    logic                    rec_valid;
    logic [TRACE_XLEN-1:0]   rec_pc;
    logic [TRACE_XLEN-1:0]   rec_inst;
    logic [TRACE_XLEN-1:0]   rec_alu_out;
    logic [TRACE_BYTE_W-1:0] rec_flags;
    logic                    tx_valid;
    logic [TRACE_BYTE_W-1:0] tx_data;
    logic                    tx_ready;

    // Transmitter side.
    modport master (
        input  rec_valid, rec_pc, rec_inst, rec_alu_out, rec_flags, tx_ready,
        output tx_valid, tx_data
    );

    // Pipeline/consumer side.
    modport slave (
        output rec_valid, rec_pc, rec_inst, rec_alu_out, rec_flags, tx_ready,
        input  tx_valid, tx_data
    );
endinterface

// File: rtl/trace_fifo.sv
// Register FIFO of trace records; a push while full succeeds only with a same-edge pop.
module trace_fifo
    import trace_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  trace_rec_t             din,
    output trace_rec_t             dout_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full_c,
    output logic                   empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en_c;
    logic          rd_en_c;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign rd_en_c = pop && !empty_c;
    assign wr_en_c = push && (!full_c || rd_en_c);
    assign dout_c  = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en_c) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en_c, rd_en_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; contents are only visible through count.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/trace_tx.sv
// Pipeline trace transmitter: buffers records and streams 14-byte frames.
module trace_tx
    import trace_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    trace_tx_if.master             bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             drop_cnt
);
    localparam int unsigned IW       = $clog2(TRACE_REC_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(TRACE_REC_BYTES - 1);

    if (XLEN != TRACE_XLEN) begin : g_xlen_chk
        $error("trace_tx: frame format requires XLEN of 32");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("trace_tx: DEPTH must be a power of two, at least 2");
    end

    tx_state_t          state;
    tx_state_t          state_d;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      idx_d;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] frame_d;
    logic               valid_q;
    logic               valid_d;
    logic               pop_c;
    logic               xfer_c;
    logic               drop_c;
    trace_rec_t         rec_c;
    trace_rec_t         head_c;
    logic               full_c;
    logic               empty_c;

    assign rec_c        = {bus.rec_flags, bus.rec_pc, bus.rec_inst, bus.rec_alu_out};
    assign xfer_c       = valid_q && bus.tx_ready;
    assign drop_c       = bus.rec_valid && full_c && !pop_c;
    assign bus.tx_valid = valid_q;
    assign bus.tx_data  = frame[TRACE_BYTE_W-1:0];

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.rec_valid),
        .pop     (pop_c),
        .din     (rec_c),
        .dout_c  (head_c),
        .count   (fifo_count),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // FSM, frame shift register and valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            frame   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            frame   <= frame_d;
            valid_q <= valid_d;
        end
    end

    // Next state: load a frame when idle, shift on each transfer, chain frames without a gap.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        frame_d = frame;
        valid_d = valid_q;
        pop_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    frame_d = build_frame(head_c);
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                valid_d = 1'b1;
                if (xfer_c) begin
                    if (idx != LAST_IDX) begin
                        idx_d   = idx + IW'(1);
                        frame_d = {8'h00, frame[FRAME_W-1:TRACE_BYTE_W]};
                    end else if (!empty_c) begin
                        pop_c   = 1'b1;
                        frame_d = build_frame(head_c);
                        idx_d   = '0;
                    end else begin
                        idx_d   = '0;
                        frame_d = '0;
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Saturating count of records lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_c && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_trace_tx.sv
// Scoreboard bench for trace_tx: expected bytes queued at push, checked by a monitor.
module tb_trace_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] fifo_count;
    logic [7:0] drop_cnt;

    trace_tx_if bus ();

    trace_tx #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] spec_bytes [14] = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h93,
                                    8'h00, 8'h50, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] exp_b;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written frame for the reference record.
    task automatic push_spec_exp();
        for (int k = 0; k < 14; k++) exp_q.push_back(spec_bytes[k]);
    endtask

    // Frame bytes for generated records: header, flags, then pc/inst/alu little-endian.
    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] alu, input logic [7:0] fl);
        exp_q.push_back(8'hA5);
        exp_q.push_back(fl);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(pc >> (8 * k)));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(inst >> (8 * k)));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(alu >> (8 * k)));
    endtask

    task automatic rec_on(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] alu, input logic [7:0] fl, input bit accept);
        bus.rec_valid   = 1'b1;
        bus.rec_pc      = pc;
        bus.rec_inst    = inst;
        bus.rec_alu_out = alu;
        bus.rec_flags   = fl;
        if (accept) push_exp(pc, inst, alu, fl);
    endtask

    task automatic spec_on();
        rec_on(32'h0000_0010, 32'h0050_0093, 32'h0000_0005, 8'h01, 1'b0);
        push_spec_exp();
    endtask

    task automatic gen_on(input int i, input bit accept);
        rec_on(32'h0000_1000 + 32'(i * 4), 32'hC0DE_0000 | 32'(i),
               32'h5500_AA00 ^ 32'(i * 257), 8'(i * 3 + 2), accept);
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (exp_q.size() == 0 && bus.tx_valid == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    // Monitor: scores each transferred byte and checks stability while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.tx_valid), 32'd1);
                    check("stall_data", 32'(bus.tx_data), 32'(prev_data));
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got 0x%0h expected no byte at %0t", bus.tx_data, $time);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("frame_byte", 32'(bus.tx_data), 32'(exp_b));
                    end
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_data  = bus.tx_data;
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.rec_valid   = 1'b0;
        bus.rec_pc      = '0;
        bus.rec_inst    = '0;
        bus.rec_alu_out = '0;
        bus.rec_flags   = '0;
        bus.tx_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single record with the consumer always ready.
        bus.tx_ready = 1'b1;
        spec_on();
        tick();
        bus.rec_valid = 1'b0;
        check("lat_count1", 32'(fifo_count), 32'd1);
        check("lat_valid0", 32'(bus.tx_valid), 32'd0);
        tick();
        check("lat_valid1", 32'(bus.tx_valid), 32'd1);
        check("lat_hdr", 32'(bus.tx_data), 32'hA5);
        check("lat_count0", 32'(fifo_count), 32'd0);
        wait_drain(40, "single_drain");

        // Same record under a 1,0,0 ready pattern.
        bus.tx_ready = 1'b0;
        spec_on();
        tick();
        bus.rec_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.tx_ready = (i % 3 == 0);
            tick();
        end
        bus.tx_ready = 1'b1;
        wait_drain(40, "bp_drain");
        check("bp_drop", 32'(drop_cnt), 32'd0);

        // Burst of six while stalled, then push on the last-byte edge while full.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gen_on(i, i != 5);
            tick();
        end
        bus.rec_valid = 1'b0;
        check("burst_count", 32'(fifo_count), 32'd4);
        check("burst_drop", 32'(drop_cnt), 32'd1);
        check("burst_hdr", 32'(bus.tx_data), 32'hA5);
        bus.tx_ready = 1'b1;
        repeat (13) tick();
        gen_on(6, 1'b1);
        tick();
        bus.rec_valid = 1'b0;
        check("fullpop_count", 32'(fifo_count), 32'd4);
        check("fullpop_drop", 32'(drop_cnt), 32'd1);
        repeat (69) tick();
        check("b2b_left", 32'(exp_q.size()), 32'd1);
        check("b2b_valid", 32'(bus.tx_valid), 32'd1);
        tick();
        check("b2b_done", 32'(exp_q.size()), 32'd0);
        check("b2b_idle", 32'(bus.tx_valid), 32'd0);

        // Drop counter saturation.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            gen_on(i, 1'b0);
            tick();
        end
        bus.rec_valid = 1'b0;
        check("sat_drop", 32'(drop_cnt), 32'd255);
        check("sat_count", 32'(fifo_count), 32'd4);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst2_valid", 32'(bus.tx_valid), 32'd0);
        check("rst2_count", 32'(fifo_count), 32'd0);
        check("rst2_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Asynchronous reset while byte 6 is on the bus.
        bus.tx_ready = 1'b1;
        spec_on();
        tick();
        bus.rec_valid = 1'b0;
        repeat (7) tick();
        check("mid_byte6", 32'(bus.tx_data), 32'h93);
        check("mid_valid", 32'(bus.tx_valid), 32'd1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("abort_valid", 32'(bus.tx_valid), 32'd0);
        check("abort_data", 32'(bus.tx_data), 32'd0);
        check("abort_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_idle", 32'(bus.tx_valid), 32'd0);
        spec_on();
        tick();
        bus.rec_valid = 1'b0;
        tick();
        check("post_hdr", 32'(bus.tx_data), 32'hA5);
        wait_drain(40, "post_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_tx.md
# trace_tx

Pipeline trace transmitter. Captures one record per asserted `rec_valid` from the CPU pipeline: PC, instruction, ALU result and hazard flags. Buffers records in a small FIFO and serializes them as fixed 14-byte frames on a byte-wide valid/ready stream. Sits beside `CPU` as the producer end of the debug/trace path that benches and on-board consumers read. It replaces ad-hoc hierarchical peeking into pipeline internals.

## Interface
Parameters:
- `DEPTH`, 4: record FIFO entries (power of two, ≥2).
- `XLEN`, 32: width of PC, instruction and ALU fields (fixed at 32 for this frame format).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `rec_valid`  in  1  a record is presented this cycle (pipeline never stalls for trace).
- `rec_pc`  in  32  PC of traced instruction.
- `rec_inst`  in  32  instruction word.
- `rec_alu_out`  in  32  EXE ALU result.
- `rec_flags`  in  8  bit0 stall, bit1 rs1 hazard, bit2 rs2 hazard, bits7:3 reserved (transmitted as given).
- `tx_valid`  out  1  `tx_data` holds a valid frame byte.
- `tx_data`  out  8  current frame byte.
- `tx_ready`  in  1  consumer accepts byte; a transfer occurs on a rising edge with `tx_valid && tx_ready`.
- `fifo_count`  out  $clog2(DEPTH)+1  records currently buffered (excludes the frame in flight).
- `drop_cnt`  out  8  records dropped due to full FIFO; saturates at 255.

## Operation
- Frame, byte order 0..13: `0xA5` header, flags, PC[7:0..31:24], INST[7:0..31:24], ALU[7:0..31:24] (little-endian per field).
- Push: on an edge with `rec_valid`, record is written if `fifo_count < DEPTH` or a pop occurs on the same edge; otherwise it is discarded and `drop_cnt` increments (saturating).
- FSM states:
  - IDLE: `tx_valid`=0. If FIFO is non-empty at the edge, pop head into the 14-byte frame register, set index=0, go to SEND.
  - SEND: `tx_valid`=1, `tx_data`=frame[index]. On a transfer with index<13: index+1. On a transfer with index=13: if FIFO is non-empty (evaluated before this edge's push), pop and load the next frame with index=0 and stay in SEND (no bubble). Otherwise go to IDLE.
- While `tx_valid && !tx_ready`, `tx_data` and index hold stable. `tx_valid` never drops mid-frame.
- Simultaneous push and pop when full: both take effect, count stays DEPTH, no drop.
- Pointers wrap modulo DEPTH. Count is tracked separately so that full and empty are unambiguous.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `fifo_count`=0, `drop_cnt`=0, FSM=IDLE, pointers=0. Assertion mid-frame aborts the frame; no partial continuation after release.
- Latency from an empty system: `rec_valid` sampled at edge N. `fifo_count`=1 after N. Frame loaded at N+1, so `tx_valid`=1 and `tx_data`=0xA5 after N+1, with `fifo_count` back to 0.
- With `tx_ready` held high, one frame takes exactly 14 cycles. Back-to-back frames have no gap.
- Sustained throughput is 1 record per 14 cycles. Faster bursts are absorbed by DEPTH, then dropped.

## Structure
- Shared header `define.vh` gains `TRACE_HDR` (8'hA5), `TRACE_REC_BYTES` (14), and flag bit indices `TRACE_F_STALL`/`TRACE_F_RS1HZD`/`TRACE_F_RS2HZD`.
- Sub-module `trace_fifo`: synchronous-write register FIFO (104-bit entry = flags+pc+inst+alu), with push/pop/count/full/empty and the push-when-full-with-pop rule.
- `trace_tx` holds the FSM, frame register, byte mux and drop counter.

## Test plan
- Single record: pc=0x00000010, inst=0x00500093, alu=0x00000005, flags=0x01, `tx_ready`=1 → bytes A5 01 10 00 00 00 93 00 50 00 05 00 00 00 on 14 consecutive cycles, starting 2 edges after push; then `tx_valid`=0.
- Backpressure: same record with `tx_ready` toggling 1,0,0,1,… → identical byte sequence, `tx_data` stable on all stalled cycles, no byte duplicated or skipped.
- Burst overflow: DEPTH=4, `tx_ready`=0, 6 consecutive `rec_valid` → first goes to frame register, `fifo_count`=4, `drop_cnt`=1. Release `tx_ready` → 5 frames emitted back-to-back (70 cycles, no bubble).
- Full + simultaneous pop: FIFO full, push on the cycle the last byte transfers → no drop, `fifo_count` stays 4.
- Drop saturation: `tx_ready`=0, 300 pushes → `drop_cnt`=255.
- Async reset mid-frame at byte index 6 → outputs zero immediately without a clock edge. After release, the next pushed record emits a fresh frame starting with 0xA5.
